prog_loader: RTL and testbench

- Host-side initiator for the CPU's external memory ports (addr_ext/wen_ext/ren_ext/wdata_ext and the *_2 set).
- Accepts a word stream over a valid/ready handshake and writes it into instruction memory, then into data memory.
- Drives the CPU enable for a programmed number of cycles, then reads back a data-memory window and emits it on an output valid/ready stream.
- Sits beside cpu in the test/FPGA top; the CPU is the responder on these ports.

---
 rtl/prog_loader_if.sv | 33 +++
 rtl/prog_loader.sv | 219 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Signal bundle between the program loader and its environment: load stream,
// readback stream, and the CPU's external IMEM/DMEM ports.
interface prog_loader_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic [31:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [31:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [31:0] wdata_ext_2;
   logic [31:0] rdata_ext_2;

   modport master (
      input  in_valid, in_data, out_ready, rdata_ext_2,
      output in_ready, out_valid, out_data,
      output addr_ext, wen_ext, ren_ext, wdata_ext,
      output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
   );

   modport slave (
      output in_valid, in_data, out_ready, rdata_ext_2,
      input  in_ready, out_valid, out_data,
      input  addr_ext, wen_ext, ren_ext, wdata_ext,
      input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
   );
endinterface

// File: rtl/prog_loader.sv
// Host-side loader: streams words into IMEM then DMEM, runs the CPU for a set
// number of cycles, then reads a DMEM window back out on a valid/ready stream.
module prog_loader #(
   parameter int RD_LAT = 1,
   parameter int LEN_W  = 16
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] imem_len,
   input  logic [LEN_W-1:0] dmem_len,
   input  logic [31:0]      run_cycles,
   input  logic [31:0]      dump_base,
   input  logic [LEN_W-1:0] dump_len,
   output logic             cpu_enable,
   output logic             busy,
   output logic             done,
   prog_loader_if.master    bus
);

   localparam int WAIT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT);

   typedef enum logic [2:0] {
      IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, FIN
   } state_e;

   // First non-empty phase among DMEM load, run, dump; FIN if all are empty.
   function automatic state_e first_phase(input logic d_nz, input logic r_nz, input logic u_nz);
      if (d_nz)      return LOAD_D;
      else if (r_nz) return RUN;
      else if (u_nz) return DUMP_RD;
      else           return FIN;
   endfunction

   state_e state_q, state_d;

   logic [LEN_W-1:0]  imem_len_q, imem_len_d, dmem_len_q, dmem_len_d;
   logic [LEN_W-1:0]  dump_len_q, dump_len_d, idx_q, idx_d;
   logic [31:0]       run_cnt_q, run_cnt_d, dump_base_q, dump_base_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              cpu_enable_q, cpu_enable_d, busy_q, busy_d, done_q, done_d;
   logic              wen_ext_q, wen_ext_d, wen_ext_2_q, wen_ext_2_d;
   logic              ren_ext_2_q, ren_ext_2_d, out_valid_q, out_valid_d;
   logic [31:0]       addr_ext_q, addr_ext_d, wdata_ext_q, wdata_ext_d;
   logic [31:0]       addr_ext_2_q, addr_ext_2_d, wdata_ext_2_q, wdata_ext_2_d;
   logic [31:0]       out_data_q, out_data_d;

   logic        in_ready_c, in_hs, out_hs, last_i, last_d, last_u;
   logic [31:0] idx_byte;

   assign in_ready_c = (state_q == LOAD_I) || (state_q == LOAD_D);
   assign in_hs      = bus.in_valid && in_ready_c;
   assign out_hs     = out_valid_q && bus.out_ready;
   assign last_i     = (idx_q == imem_len_q - LEN_W'(1));
   assign last_d     = (idx_q == dmem_len_q - LEN_W'(1));
   assign last_u     = (idx_q == dump_len_q - LEN_W'(1));
   assign idx_byte   = 32'(idx_q) << 2;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:
            if (start) begin
               if (imem_len != '0) state_d = LOAD_I;
               else state_d = first_phase(dmem_len != '0, run_cycles != '0, dump_len != '0);
            end
         LOAD_I:
            if (in_hs && last_i)
               state_d = first_phase(dmem_len_q != '0, run_cnt_q != '0, dump_len_q != '0);
         LOAD_D:
            if (in_hs && last_d)
               state_d = first_phase(1'b0, run_cnt_q != '0, dump_len_q != '0);
         RUN:
            if (run_cnt_q == '0) state_d = first_phase(1'b0, 1'b0, dump_len_q != '0);
         DUMP_RD:   state_d = DUMP_WAIT;
         DUMP_WAIT: if (wait_q == WAIT_LAST) state_d = DUMP_OUT;
         DUMP_OUT:  if (out_hs) state_d = last_u ? FIN : DUMP_RD;
         FIN:       state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      imem_len_d    = imem_len_q;
      dmem_len_d    = dmem_len_q;
      dump_len_d    = dump_len_q;
      run_cnt_d     = run_cnt_q;
      dump_base_d   = dump_base_q;
      idx_d         = idx_q;
      wait_d        = wait_q;
      addr_ext_d    = addr_ext_q;
      wdata_ext_d   = wdata_ext_q;
      addr_ext_2_d  = addr_ext_2_q;
      wdata_ext_2_d = wdata_ext_2_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      wen_ext_d     = 1'b0;
      wen_ext_2_d   = 1'b0;
      ren_ext_2_d   = 1'b0;
      cpu_enable_d  = 1'b0;
      busy_d        = (state_d != IDLE);
      done_d        = (state_q == FIN);
      case (state_q)
         IDLE:
            if (start) begin
               imem_len_d  = imem_len;
               dmem_len_d  = dmem_len;
               dump_len_d  = dump_len;
               run_cnt_d   = run_cycles;
               dump_base_d = dump_base;
               idx_d       = '0;
            end
         LOAD_I:
            if (in_hs) begin
               wen_ext_d   = 1'b1;
               addr_ext_d  = idx_byte;
               wdata_ext_d = bus.in_data;
               idx_d       = last_i ? '0 : idx_q + LEN_W'(1);
            end
         LOAD_D:
            if (in_hs) begin
               wen_ext_2_d   = 1'b1;
               addr_ext_2_d  = idx_byte;
               wdata_ext_2_d = bus.in_data;
               idx_d         = last_d ? '0 : idx_q + LEN_W'(1);
            end
         // Enable is registered, so it starts the cycle after RUN is entered.
         RUN:
            if (run_cnt_q != '0) begin
               cpu_enable_d = 1'b1;
               run_cnt_d    = run_cnt_q - 32'd1;
            end
         DUMP_RD: begin
            ren_ext_2_d  = 1'b1;
            addr_ext_2_d = dump_base_q + idx_byte;
            wait_d       = '0;
         end
         DUMP_WAIT:
            if (wait_q == WAIT_LAST) begin
               out_data_d  = bus.rdata_ext_2;
               out_valid_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         DUMP_OUT:
            if (out_hs) begin
               out_valid_d = 1'b0;
               idx_d       = last_u ? '0 : idx_q + LEN_W'(1);
            end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         imem_len_q    <= '0;
         dmem_len_q    <= '0;
         dump_len_q    <= '0;
         run_cnt_q     <= '0;
         dump_base_q   <= '0;
         idx_q         <= '0;
         wait_q        <= '0;
         addr_ext_q    <= '0;
         wdata_ext_q   <= '0;
         addr_ext_2_q  <= '0;
         wdata_ext_2_q <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         wen_ext_q     <= 1'b0;
         wen_ext_2_q   <= 1'b0;
         ren_ext_2_q   <= 1'b0;
         cpu_enable_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         imem_len_q    <= imem_len_d;
         dmem_len_q    <= dmem_len_d;
         dump_len_q    <= dump_len_d;
         run_cnt_q     <= run_cnt_d;
         dump_base_q   <= dump_base_d;
         idx_q         <= idx_d;
         wait_q        <= wait_d;
         addr_ext_q    <= addr_ext_d;
         wdata_ext_q   <= wdata_ext_d;
         addr_ext_2_q  <= addr_ext_2_d;
         wdata_ext_2_q <= wdata_ext_2_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         wen_ext_q     <= wen_ext_d;
         wen_ext_2_q   <= wen_ext_2_d;
         ren_ext_2_q   <= ren_ext_2_d;
         cpu_enable_q  <= cpu_enable_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.addr_ext    = addr_ext_q;
   assign bus.wen_ext     = wen_ext_q;
   assign bus.ren_ext     = 1'b0;
   assign bus.wdata_ext   = wdata_ext_q;
   assign bus.addr_ext_2  = addr_ext_2_q;
   assign bus.wen_ext_2   = wen_ext_2_q;
   assign bus.ren_ext_2   = ren_ext_2_q;
   assign bus.wdata_ext_2 = wdata_ext_2_q;
   assign cpu_enable      = cpu_enable_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and randomized load/run/dump sequences checked
// against a transaction-level model of the expected writes, enables and readback.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        arst_n, start;
   logic [15:0] imem_len, dmem_len, dump_len;
   logic [31:0] run_cycles, dump_base;
   logic        cpu_enable, busy, done;

   prog_loader_if bus();

   prog_loader #(.RD_LAT(1), .LEN_W(16)) dut (
      .clk(clk), .arst_n(arst_n), .start(start),
      .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles),
      .dump_base(dump_base), .dump_len(dump_len),
      .cpu_enable(cpu_enable), .busy(busy), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;

   int errors, checks, cyc;
   logic [31:0] istream[$], dstream[$];
   logic [31:0] ref_mem [logic [31:0]];

   // Background DMEM contents for never-written locations.
   function automatic logic [31:0] bg(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5EED0000;
   endfunction

   // DMEM responder with one cycle of read latency.
   logic [31:0] mem_arr [256];
   bit          mem_vld [256];
   always @(posedge clk) begin
      if (bus.wen_ext_2) begin
         mem_arr[bus.addr_ext_2[9:2]] <= bus.wdata_ext_2;
         mem_vld[bus.addr_ext_2[9:2]] <= 1'b1;
      end
      if (bus.ren_ext_2)
         bus.rdata_ext_2 <= mem_vld[bus.addr_ext_2[9:2]] ? mem_arr[bus.addr_ext_2[9:2]] : bg(bus.addr_ext_2);
   end

   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$], rd_a[$], od[$];
   int          iw_c[$], hs_c[$], en_c[$], done_c[$];
   int          strobe_en, ren1, stall_bad, busy_n, done_busy;
   bit          pv, pr;
   logic [31:0] pd;
   always @(negedge clk) begin
      if (bus.wen_ext) begin iw_a.push_back(bus.addr_ext); iw_d.push_back(bus.wdata_ext); iw_c.push_back(cyc); end
      if (bus.wen_ext_2) begin dw_a.push_back(bus.addr_ext_2); dw_d.push_back(bus.wdata_ext_2); end
      if (bus.ren_ext_2) rd_a.push_back(bus.addr_ext_2);
      if (bus.in_valid && bus.in_ready) hs_c.push_back(cyc);
      if (cpu_enable) en_c.push_back(cyc);
      if (done) done_c.push_back(cyc);
      if (bus.out_valid && bus.out_ready) od.push_back(bus.out_data);
      if (cpu_enable && (bus.wen_ext || bus.wen_ext_2 || bus.ren_ext_2)) strobe_en <= strobe_en + 1;
      if (bus.ren_ext) ren1 <= ren1 + 1;
      if (busy) busy_n <= busy_n + 1;
      if (done && busy) done_busy <= done_busy + 1;
      if (pv && !pr && (!bus.out_valid || bus.out_data !== pd)) stall_bad <= stall_bad + 1;
      if (pv && pr && bus.out_valid) stall_bad <= stall_bad + 1;
      pv <= bus.out_valid;
      pr <= bus.out_ready;
      pd <= bus.out_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] w, input int gap);
      int n;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.in_ready && n < 200);
      check("in_wait", 32'(n < 200), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic receive(input int ul, input int stall_idx, input int stall_n);
      int n;
      for (int k = 0; k < ul; k++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!bus.out_valid && n < 500);
         check("out_wait", 32'(n < 500), 32'd1);
         if (k == stall_idx) repeat (stall_n) @(negedge clk);
         @(posedge clk); #1; bus.out_ready = 1'b1;
         @(posedge clk); #1; bus.out_ready = 1'b0;
      end
   endtask

   task automatic run_seq(input int il, input int dl, input logic [31:0] rc, input logic [31:0] base,
                          input int ul, input int igap, input int dgap, input int stall_idx, input int stall_n);
      int iw0, dw0, hs0, en0, od0, rd0, dn0, bz0, se0, sb0, db0, start_cyc, ref_cyc, n;
      logic [31:0] a, ew;
      iw0 = iw_a.size(); dw0 = dw_a.size(); hs0 = hs_c.size(); en0 = en_c.size();
      od0 = od.size(); rd0 = rd_a.size(); dn0 = done_c.size();
      bz0 = busy_n; se0 = strobe_en; sb0 = stall_bad; db0 = done_busy;
      imem_len = 16'(il); dmem_len = 16'(dl); run_cycles = rc; dump_base = base; dump_len = 16'(ul);
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      // Config must be latched: scramble it for the rest of the sequence.
      imem_len = 16'($urandom); dmem_len = 16'($urandom); dump_len = 16'($urandom);
      run_cycles = $urandom; dump_base = $urandom;
      for (int k = 0; k < il; k++) send(istream[k], (igap < 0) ? int'($urandom_range(0, 2)) : igap);
      for (int k = 0; k < dl; k++) begin
         send(dstream[k], (dgap < 0) ? int'($urandom_range(0, 2)) : dgap);
         ref_mem[32'(k) << 2] = dstream[k];
      end
      if (il + dl > 0) begin @(negedge clk); check("in_ready_off", 32'(bus.in_ready), 32'd0); end
      receive(ul, stall_idx, stall_n);
      n = 0;
      while (done_c.size() == dn0 && n < 1000) begin @(negedge clk); n++; end
      check("done_seen", 32'(n < 1000), 32'd1);
      repeat (3) @(negedge clk);

      check("hs_cnt", hs_c.size() - hs0, il + dl);
      check("imem_cnt", iw_a.size() - iw0, il);
      for (int k = 0; k < il && iw0 + k < iw_a.size(); k++) begin
         check("imem_addr", iw_a[iw0 + k], 32'(k) << 2);
         check("imem_data", iw_d[iw0 + k], istream[k]);
      end
      if (igap == 0 && il > 1 && iw_a.size() - iw0 == il)
         check("imem_b2b", iw_c[iw0 + il - 1] - iw_c[iw0], il - 1);
      check("dmem_cnt", dw_a.size() - dw0, dl);
      for (int k = 0; k < dl && dw0 + k < dw_a.size(); k++) begin
         check("dmem_addr", dw_a[dw0 + k], 32'(k) << 2);
         check("dmem_data", dw_d[dw0 + k], dstream[k]);
      end
      check("en_cnt", en_c.size() - en0, rc);
      if (rc > 0 && en_c.size() > en0) begin
         ref_cyc = (il + dl > 0 && hs_c.size() > 0) ? hs_c[hs_c.size() - 1] : start_cyc;
         check("en_first", en_c[en0], ref_cyc + 2);
         check("en_contig", en_c[en_c.size() - 1] - en_c[en0], en_c.size() - en0 - 1);
      end
      check("strobe_with_en", strobe_en - se0, 0);
      check("rd_cnt", rd_a.size() - rd0, ul);
      for (int k = 0; k < ul && rd0 + k < rd_a.size(); k++)
         check("rd_addr", rd_a[rd0 + k], base + (32'(k) << 2));
      check("out_cnt", od.size() - od0, ul);
      for (int k = 0; k < ul && od0 + k < od.size(); k++) begin
         a  = base + (32'(k) << 2);
         ew = ref_mem.exists(a) ? ref_mem[a] : bg(a);
         check("out_data", od[od0 + k], ew);
      end
      check("out_stable", stall_bad - sb0, 0);
      check("done_cnt", done_c.size() - dn0, 1);
      check("done_busy", done_busy - db0, 0);
      if (il == 0 && dl == 0 && rc == 0 && ul == 0) begin
         check("zero_busy_cycles", busy_n - bz0, 1);
         if (done_c.size() > dn0) check("zero_done_cyc", done_c[dn0], start_cyc + 2);
      end
      check("end_idle", {29'd0, busy, bus.out_valid, cpu_enable}, 32'd0);
   endtask

   initial begin
      int il, dl, ul, n, en0, bz0;
      logic [31:0] rc, base;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      start = 1'b0; imem_len = '0; dmem_len = '0; dump_len = '0; run_cycles = '0; dump_base = '0;
      arst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", {23'd0, busy, done, cpu_enable, bus.wen_ext, bus.wen_ext_2, bus.ren_ext_2,
                         bus.ren_ext, bus.out_valid, bus.in_ready}, 32'd0);
      check("rst_addr", bus.addr_ext | bus.addr_ext_2, 32'd0);
      check("rst_data", bus.wdata_ext | bus.wdata_ext_2 | bus.out_data, 32'd0);
      @(posedge clk); #1; arst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_ctrl", {29'd0, busy, done, bus.in_ready}, 32'd0);

      istream = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003};
      dstream = '{$urandom, $urandom};
      run_seq(3, 2, 32'd5, 32'h10, 3, 0, 2, 1, 4);

      run_seq(0, 0, 32'd0, 32'd0, 0, 0, 0, -1, 0);

      // Abort mid-RUN with the asynchronous reset.
      istream = '{$urandom}; dstream = '{$urandom};
      imem_len = 16'd1; dmem_len = 16'd1; run_cycles = 32'd20; dump_base = '0; dump_len = 16'd2;
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      send(istream[0], 0);
      send(dstream[0], 0);
      ref_mem[32'd0] = dstream[0];
      n = 0;
      do begin @(negedge clk); n++; end while (!cpu_enable && n < 100);
      check("rst_en_seen", 32'(n < 100), 32'd1);
      @(posedge clk); #1; arst_n = 1'b0; #1;
      check("rst_async_en", 32'(cpu_enable), 32'd0);
      check("rst_async_busy", 32'(busy), 32'd0);
      @(posedge clk); #1; arst_n = 1'b1;
      en0 = en_c.size(); bz0 = busy_n;
      repeat (5) @(negedge clk);
      check("rst_no_resume", (en_c.size() - en0) + (busy_n - bz0), 0);

      for (int t = 0; t < 6; t++) begin
         il = $urandom_range(0, 4); dl = $urandom_range(0, 4); ul = $urandom_range(0, 4);
         rc = 32'($urandom_range(0, 8));
         base = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : (32'($urandom_range(0, 16)) << 2);
         istream.delete(); dstream.delete();
         for (int k = 0; k < il; k++) istream.push_back($urandom);
         for (int k = 0; k < dl; k++) dstream.push_back($urandom);
         run_seq(il, dl, rc, base, ul, -1, -1, int'($urandom_range(0, ul)), int'($urandom_range(0, 3)));
      end

      check("ren_ext_never", ren1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
